mem_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch port (PC side) and the data-memory port (load/store side) of the RV32I core.
- Issues one transaction at a time, tracks read latency and routes read data back to the owner.
- Data port has priority, with a starvation guard for fetch.
- Sits between the core and the unified memory; the core stalls while gnt/rvalid are pending.

---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 34 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package arb_pkg;

    // Width of the latency and starvation counters (both legal up to 15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of fetch requests denied in favour of the data port.
// at_max tells the arbiter that fetch must win the next conflict.
module arb_starve_ctr
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == CNT_W'(STARVE_MAX));
    assign at_max   = w_at_max;

    // Count denied fetch cycles, clear on a fetch grant, saturate at the limit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch port and
// the data port. Data wins by default; a starvation guard forces a fetch grant
// after STARVE_MAX denied conflicts. One read may be outstanding at a time.
// Optional statistics counters are compiled in with `define ARB_STATS_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic                    dm_gnt,
    output logic                    dm_rvalid,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]             stat_if_grants,
    output logic [31:0]             stat_dm_grants,
    output logic [31:0]             stat_conflicts
`endif
);

    state_e           r_state;
    owner_e           r_owner;
    logic [CNT_W-1:0] r_lat_cnt;

    logic w_rd_done;
    logic w_grantable;
    logic w_if_win;
    logic w_dm_win;
    logic w_rd_issue;
    logic w_at_max;

    // The pending read completes this cycle; the memory port is free again.
    assign w_rd_done   = (r_state == ST_RD_WAIT) && (r_lat_cnt == '0);
    assign w_grantable = (r_state == ST_IDLE) || w_rd_done;

    // Data wins conflicts unless fetch has been denied STARVE_MAX times.
    assign w_if_win   = w_grantable && if_req && (!dm_req || w_at_max);
    assign w_dm_win   = w_grantable && dm_req && !w_if_win;
    assign w_rd_issue = w_if_win || (w_dm_win && !dm_we);

    assign if_gnt = w_if_win;
    assign dm_gnt = w_dm_win;
    assign busy   = (r_state == ST_RD_WAIT);

    // Steer the winner's request onto the memory bus; idle bus is all zeros.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (w_if_win) begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
            mem_be   = '1;
        end else if (w_dm_win) begin
            mem_req   = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_be    = dm_be;
        end
    end

    // Route returning read data to its owner only; the other port sees zero.
    always_comb begin
        if_rvalid = w_rd_done && (r_owner == OWN_IF);
        dm_rvalid = w_rd_done && (r_owner == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

    // Track the single outstanding read: owner and remaining latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_NONE;
            r_lat_cnt <= '0;
        end else if (w_rd_issue) begin
            r_state   <= ST_RD_WAIT;
            r_owner   <= w_if_win ? OWN_IF : OWN_DM;
            r_lat_cnt <= CNT_W'(MEM_LATENCY - 1);
        end else if (r_state == ST_RD_WAIT) begin
            if (r_lat_cnt == '0) begin
                r_state <= ST_IDLE;
                r_owner <= OWN_NONE;
            end else begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_grantable && if_req && w_dm_win),
        .clr    (w_if_win),
        .at_max (w_at_max)
    );

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_if;
    logic [31:0] r_stat_dm;
    logic [31:0] r_stat_conf;

    // Free-running grant and conflict counters; wrap silently on overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_if   <= '0;
            r_stat_dm   <= '0;
            r_stat_conf <= '0;
        end else begin
            if (w_if_win) r_stat_if <= r_stat_if + 32'd1;
            if (w_dm_win) r_stat_dm <= r_stat_dm + 32'd1;
            if (w_grantable && if_req && dm_req) r_stat_conf <= r_stat_conf + 32'd1;
        end
    end

    assign stat_if_grants = r_stat_if;
    assign stat_dm_grants = r_stat_dm;
    assign stat_conflicts = r_stat_conf;
`endif

endmodule
